// File: rtl/mmio_io_unit.sv
// Board I/O peripheral: synchronized and debounced switches/buttons, latched press
// events, and a software-written hex word driven onto eight active-low 7-segment digits.
module mmio_io_unit #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_sel,
  input  logic [3:0]  addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic [15:0] switch_array,
  input  logic        button0,
  input  logic        button1,
  input  logic        button2,
  input  logic        button3,
  output logic [6:0]  seg0,
  output logic [6:0]  seg1,
  output logic [6:0]  seg2,
  output logic [6:0]  seg3,
  output logic [6:0]  seg4,
  output logic [6:0]  seg5,
  output logic [6:0]  seg6,
  output logic [6:0]  seg7
);

  localparam int NIN = 20;
  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NIN-1:0] raw_in, sync_q1, sync_q2, deb_q, deb_nxt;
  logic [CW-1:0]  cnt_q   [NIN];
  logic [CW-1:0]  cnt_nxt [NIN];
  logic [3:0]     btn_rise, flag_q;
  logic [31:0]    disp_q, rd_mux;
  logic [8:0]     ctrl_q;
  logic [1:0]     reg_sel;
  logic           rd_hit, wr_hit;
  logic [6:0]     seg_nxt [8];
  logic           unused_addr;

  assign raw_in      = {button3, button2, button1, button0, switch_array};
  assign reg_sel     = addr[3:2];
  assign unused_addr = ^addr[1:0];
  assign rd_hit      = io_sel & rd_en;
  assign wr_hit      = io_sel & wr_en;

  // The cycle that would bring the count to DEBOUNCE_CYCLES is the one that commits
  // the new level, so the stored count never exceeds DEBOUNCE_CYCLES-1.
  always_comb begin
    deb_nxt = deb_q;
    for (int i = 0; i < NIN; i++) begin
      cnt_nxt[i] = '0;
      if (sync_q2[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_nxt[i] = sync_q2[i];
        else                      cnt_nxt[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      deb_q   <= '0;
      for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
    end else begin
      sync_q1 <= raw_in;
      sync_q2 <= sync_q1;
      deb_q   <= deb_nxt;
      for (int i = 0; i < NIN; i++) cnt_q[i] <= cnt_nxt[i];
    end
  end

  assign btn_rise = deb_nxt[19:16] & ~deb_q[19:16];

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      2'd0:    rd_mux = {16'b0, deb_q[15:0]};
      2'd1:    rd_mux = {24'b0, flag_q, deb_q[19:16]};
      2'd2:    rd_mux = disp_q;
      default: rd_mux = {23'b0, ctrl_q};
    endcase
  end

  // A BUTTON read clears the flags, but a press landing on the same edge survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
      flag_q  <= '0;
      disp_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      if (rd_hit) rd_data <= rd_mux;
      if (rd_hit && reg_sel == 2'd1) flag_q <= btn_rise;
      else                           flag_q <= flag_q | btn_rise;
      if (wr_hit && reg_sel == 2'd2) disp_q <= wr_data;
      if (wr_hit && reg_sel == 2'd3) ctrl_q <= wr_data[8:0];
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      seg_nxt[i] = 7'h7F;
      if (ctrl_q[8] && !ctrl_q[i]) seg_nxt[i] = hex7(disp_q[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg0 <= 7'h7F; seg1 <= 7'h7F; seg2 <= 7'h7F; seg3 <= 7'h7F;
      seg4 <= 7'h7F; seg5 <= 7'h7F; seg6 <= 7'h7F; seg7 <= 7'h7F;
    end else begin
      seg0 <= seg_nxt[0]; seg1 <= seg_nxt[1]; seg2 <= seg_nxt[2]; seg3 <= seg_nxt[3];
      seg4 <= seg_nxt[4]; seg5 <= seg_nxt[5]; seg6 <= seg_nxt[6]; seg7 <= seg_nxt[7];
    end
  end

endmodule
